// File: rtl/permutation_xor.sv
// One ASCON permutation round per clock (p_C, p_S, p_L) on a 320-bit state
// register, with optional data absorb before the round and key injection after it.
module permutation_xor (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              input_select_i,
    input  logic              ena_cpt_i,
    input  logic              init_a_i,
    input  logic              init_b_i,
    input  logic              ena_xor_up_i,
    input  logic              ena_xor_down_i,
    input  logic              ena_reg_state_i,
    input  logic [0:4][63:0]  permutation_i,
    input  logic [63:0]       data_xor_up_i,
    input  logic [255:0]      data_xor_down_i,
    input  logic              ena_cipher_i,
    input  logic              ena_tag_i,
    output logic [0:4][63:0]  permutation_o,
    output logic [3:0]        round_o,
    output logic [63:0]       cipher_o,
    output logic [127:0]      tag_o
);

    typedef logic [0:4][63:0] state_t;

    state_t       state_p0;
    logic [3:0]   round_p0;
    logic [63:0]  cipher_p0;
    logic [127:0] tag_p0;

    state_t m_in;
    state_t u_up;
    state_t c_add;
    state_t s_box;
    state_t l_lin;
    state_t d_down;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {~r, r};
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once, S0 = column MSB.
    function automatic state_t sbox_layer(input state_t s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        state_t      r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic state_t linear_layer(input state_t s);
        state_t r;
        r[0] = s[0] ^ rotr64(s[0], 19) ^ rotr64(s[0], 28);
        r[1] = s[1] ^ rotr64(s[1], 61) ^ rotr64(s[1], 39);
        r[2] = s[2] ^ rotr64(s[2], 1)  ^ rotr64(s[2], 6);
        r[3] = s[3] ^ rotr64(s[3], 10) ^ rotr64(s[3], 17);
        r[4] = s[4] ^ rotr64(s[4], 7)  ^ rotr64(s[4], 41);
        return r;
    endfunction

    always_comb begin
        m_in = input_select_i ? state_p0 : state_t'(permutation_i);

        u_up = m_in;
        if (ena_xor_up_i)
            u_up[0] = u_up[0] ^ data_xor_up_i;

        c_add = u_up;
        c_add[2][7:0] = c_add[2][7:0] ^ round_const(round_p0);

        s_box = sbox_layer(c_add);
        l_lin = linear_layer(s_box);

        d_down = l_lin;
        if (ena_xor_down_i)
            d_down[1:4] = d_down[1:4] ^ data_xor_down_i;
    end

    // ---- register stage: round result, counter, capture registers ----
    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state_p0  <= '0;
            round_p0  <= '0;
            cipher_p0 <= '0;
            tag_p0    <= '0;
        end else begin
            if (ena_reg_state_i)
                state_p0 <= d_down;
            if (init_a_i)
                round_p0 <= 4'd0;
            else if (init_b_i)
                round_p0 <= 4'd6;
            else if (ena_cpt_i)
                round_p0 <= round_p0 + 4'd1;
            if (ena_cipher_i)
                cipher_p0 <= u_up[0];
            if (ena_tag_i)
                tag_p0 <= {d_down[3], d_down[4]};
        end
    end

    assign permutation_o = state_p0;
    assign round_o       = round_p0;
    assign cipher_o      = cipher_p0;
    assign tag_o         = tag_p0;

endmodule

// File: tb/tb_permutation_xor.sv
// Scoreboard bench for permutation_xor: directed vectors push expected outputs,
// a negedge monitor drains the queue and compares against the DUT.
module tb_permutation_xor;

    logic              clock_i = 1'b0;
    logic              resetb_i;
    logic              input_select_i;
    logic              ena_cpt_i;
    logic              init_a_i;
    logic              init_b_i;
    logic              ena_xor_up_i;
    logic              ena_xor_down_i;
    logic              ena_reg_state_i;
    logic [0:4][63:0]  permutation_i;
    logic [63:0]       data_xor_up_i;
    logic [255:0]      data_xor_down_i;
    logic              ena_cipher_i;
    logic              ena_tag_i;
    logic [0:4][63:0]  permutation_o;
    logic [3:0]        round_o;
    logic [63:0]       cipher_o;
    logic [127:0]      tag_o;

    permutation_xor dut (
        .clock_i         (clock_i),
        .resetb_i        (resetb_i),
        .input_select_i  (input_select_i),
        .ena_cpt_i       (ena_cpt_i),
        .init_a_i        (init_a_i),
        .init_b_i        (init_b_i),
        .ena_xor_up_i    (ena_xor_up_i),
        .ena_xor_down_i  (ena_xor_down_i),
        .ena_reg_state_i (ena_reg_state_i),
        .permutation_i   (permutation_i),
        .data_xor_up_i   (data_xor_up_i),
        .data_xor_down_i (data_xor_down_i),
        .ena_cipher_i    (ena_cipher_i),
        .ena_tag_i       (ena_tag_i),
        .permutation_o   (permutation_o),
        .round_o         (round_o),
        .cipher_o        (cipher_o),
        .tag_o           (tag_o)
    );

    always #5 clock_i = ~clock_i;

    // sel: 0..4 state word Sx, 5 round_o, 6 cipher_o, 7 tag_o
    typedef struct {
        string        name;
        int           sel;
        logic [127:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] R0_S0 = 64'h001E0F00000000F0;
    localparam logic [63:0] R0_S1 = 64'h00000001E0000770;
    localparam logic [63:0] R0_S2 = 64'h3FFFFFFFFFFFFF74;
    localparam logic [63:0] R0_S3 = 64'h3C780000000000F0;
    localparam logic [63:0] R6_S0 = 64'h0012C96000000096;
    localparam logic [63:0] IV    = 64'h80400C0600000000;
    localparam logic [127:0] KEY  = 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF;
    localparam logic [127:0] TAG0 = 128'hB62D114D1CB6A952BE263D4D7AECAAFF;

    task automatic chk(input string n, input int sel, input logic [127:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic clear_in();
        resetb_i        = 1'b0;
        input_select_i  = 1'b0;
        ena_cpt_i       = 1'b0;
        init_a_i        = 1'b0;
        init_b_i        = 1'b0;
        ena_xor_up_i    = 1'b0;
        ena_xor_down_i  = 1'b0;
        ena_reg_state_i = 1'b0;
        permutation_i   = '0;
        data_xor_up_i   = '0;
        data_xor_down_i = '0;
        ena_cipher_i    = 1'b0;
        ena_tag_i       = 1'b0;
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        resetb_i = 1'b1;
        step();
        clear_in();
    endtask

    // Monitor: outputs are registered, so everything queued after an edge is
    // compared on the following falling edge.
    always @(negedge clock_i) begin
        while (sb.size() > 0) begin
            exp_t         e;
            logic [127:0] act;
            e = sb.pop_front();
            case (e.sel)
                0, 1, 2, 3, 4: act = {64'd0, permutation_o[e.sel]};
                5:             act = {124'd0, round_o};
                6:             act = {64'd0, cipher_o};
                default:       act = tag_o;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        clear_in();
        do_reset();

        // Dirty everything, then reset with all enables high.
        ena_reg_state_i = 1'b1;
        ena_xor_up_i    = 1'b1;
        data_xor_up_i   = IV;
        ena_cipher_i    = 1'b1;
        ena_tag_i       = 1'b1;
        init_b_i        = 1'b1;
        step();
        resetb_i        = 1'b1;
        ena_cpt_i       = 1'b1;
        step();
        chk("rst_s0", 0, 128'd0);
        chk("rst_s2", 2, 128'd0);
        chk("rst_round", 5, 128'd0);
        chk("rst_cipher", 6, 128'd0);
        chk("rst_tag", 7, 128'd0);
        clear_in();

        // Single round on zero input, round 0.
        ena_reg_state_i = 1'b1;
        step();
        chk("r0_s0", 0, {64'd0, R0_S0});
        chk("r0_s1", 1, {64'd0, R0_S1});
        chk("r0_s2", 2, {64'd0, R0_S2});
        chk("r0_s3", 3, {64'd0, R0_S3});
        chk("r0_s4", 4, 128'd0);
        chk("r0_round", 5, 128'd0);

        // State holds without ena_reg_state; counter still counts.
        clear_in();
        permutation_i = {64'h1111, 64'h2222, 64'h3333, 64'h4444, 64'h5555};
        ena_cpt_i     = 1'b1;
        step();
        chk("hold_s0", 0, {64'd0, R0_S0});
        chk("hold_s2", 2, {64'd0, R0_S2});
        chk("hold_round", 5, 128'd1);

        // Counter sequence for p^a.
        clear_in();
        init_a_i = 1'b1;
        step();
        chk("cnt_a", 5, 128'd0);
        clear_in();
        ena_cpt_i = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk($sformatf("cnt_%0d", i), 5, 128'(i));
        end

        // Counter priorities and wrap.
        clear_in();
        init_b_i = 1'b1;
        step();
        chk("cnt_b", 5, 128'd6);
        init_a_i = 1'b1;
        step();
        chk("cnt_a_over_b", 5, 128'd0);
        init_a_i  = 1'b0;
        ena_cpt_i = 1'b1;
        step();
        chk("cnt_b_over_cpt", 5, 128'd6);
        init_b_i = 1'b0;
        repeat (9) step();
        chk("cnt_15", 5, 128'd15);
        step();
        chk("cnt_wrap", 5, 128'd0);

        // Round constant from round 6; the round uses the pre-edge counter.
        do_reset();
        init_b_i = 1'b1;
        step();
        clear_in();
        ena_reg_state_i = 1'b1;
        ena_cpt_i       = 1'b1;
        step();
        chk("r6_s0", 0, {64'd0, R6_S0});
        chk("r6_round_after", 5, 128'd7);

        // input_select=1 takes the (zeroed) state register, not permutation_i.
        do_reset();
        permutation_i   = {64'hDEADBEEF, 64'hCAFE, 64'h1234, 64'h5678, 64'h9ABC};
        input_select_i  = 1'b1;
        ena_reg_state_i = 1'b1;
        step();
        chk("sel_s0", 0, {64'd0, R0_S0});
        chk("sel_s1", 1, {64'd0, R0_S1});

        // xor_up into S0 captured as cipher; state not loaded.
        do_reset();
        ena_xor_up_i  = 1'b1;
        data_xor_up_i = IV;
        ena_cipher_i  = 1'b1;
        step();
        chk("cipher", 6, {64'd0, IV});
        chk("cipher_state_s0", 0, 128'd0);

        // xor_down key injection captured as tag and loaded into state.
        clear_in();
        ena_xor_down_i         = 1'b1;
        data_xor_down_i[127:0] = KEY;
        ena_tag_i              = 1'b1;
        ena_reg_state_i        = 1'b1;
        step();
        chk("tag", 7, TAG0);
        chk("tag_s3", 3, {64'd0, TAG0[127:64]});
        chk("tag_s4", 4, {64'd0, TAG0[63:0]});
        chk("tag_s0", 0, {64'd0, R0_S0});
        chk("cipher_hold", 6, {64'd0, IV});

        // xor_up and xor_down together: absorb cancels S0, key hits S1 after the round.
        do_reset();
        permutation_i            = {IV, 64'd0, 64'd0, 64'd0, 64'd0};
        ena_xor_up_i             = 1'b1;
        data_xor_up_i            = IV;
        ena_xor_down_i           = 1'b1;
        data_xor_down_i[255:192] = 64'hFFFF0000FFFF0000;
        ena_cipher_i             = 1'b1;
        ena_reg_state_i          = 1'b1;
        step();
        chk("both_s0", 0, {64'd0, R0_S0});
        chk("both_s1", 1, {64'd0, R0_S1 ^ 64'hFFFF0000FFFF0000});
        chk("both_s4", 4, 128'd0);
        chk("both_cipher", 6, 128'd0);

        clear_in();
        for (int i = 0; i < 50 && sb.size() > 0; i++)
            @(negedge clock_i);
        #1;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish by 50000");
        $fatal(1, "timeout");
    end

endmodule
